// File: rtl/frequency_counter_calibrator_if.sv
// Sample-in / bit-out handshake between the frequency counter, the calibrator and the deframer.
interface frequency_counter_calibrator_if;
  logic [15:0] sample_i;
  logic        sample_valid_i;
  logic        bit_ready_i;
  logic        bit_o;
  logic        bit_valid_o;

  modport slave (
    input  sample_i, sample_valid_i, bit_ready_i,
    output bit_o, bit_valid_o
  );

  modport master (
    output sample_i, sample_valid_i, bit_ready_i,
    input  bit_o, bit_valid_o
  );
endinterface

// File: rtl/frequency_counter_calibrator.sv
// Discards settling samples, averages 2^LOG2_AVG period counts into a threshold,
// then slices each later sample into a bit delivered over valid/ready.
module frequency_counter_calibrator #(
  parameter int unsigned SETTLE_SAMPLES = 4,
  parameter int unsigned LOG2_AVG       = 6
) (
  input  logic                                clk_200M,
  input  logic                                reset_n_200M,
  input  logic                                start_i,
  frequency_counter_calibrator_if.slave       bus,
  output logic [15:0]                         compare_point_o,
  output logic                                calibrated_o,
  output logic                                busy_o,
  output logic                                overrun_o
);

  localparam int unsigned ACC_W       = 16 + LOG2_AVG;
  localparam logic [8:0]  SETTLE_LAST = 9'(SETTLE_SAMPLES - 1);
  localparam logic [8:0]  AVG_LAST    = 9'((1 << LOG2_AVG) - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, RUN} state_t;

  state_t             state, state_next;
  logic [8:0]         cnt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   sum;
  logic               take;
  logic               settle_done;
  logic               accum_done;
  logic               new_bit;

  // start_i wins over a coincident sample, so the sample is masked here.
  assign take        = bus.sample_valid_i && !start_i;
  assign settle_done = take && (state == SETTLE) && (cnt == SETTLE_LAST);
  assign accum_done  = take && (state == ACCUM) && (cnt == AVG_LAST);
  assign new_bit     = take && (state == RUN);
  assign sum         = acc + ACC_W'(bus.sample_i);

  always_ff @(posedge clk_200M or negedge reset_n_200M) begin
    if (!reset_n_200M) state <= IDLE;
    else               state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start_i)          state_next = (SETTLE_SAMPLES == 0) ? ACCUM : SETTLE;
    else if (settle_done) state_next = ACCUM;
    else if (accum_done)  state_next = RUN;
  end

  always_comb begin
    busy_o = (state == SETTLE) || (state == ACCUM);
  end

  always_ff @(posedge clk_200M or negedge reset_n_200M) begin
    if (!reset_n_200M) begin
      acc             <= '0;
      cnt             <= '0;
      compare_point_o <= '0;
      calibrated_o    <= 1'b0;
      overrun_o       <= 1'b0;
      bus.bit_o       <= 1'b0;
      bus.bit_valid_o <= 1'b0;
    end else if (start_i) begin
      acc             <= '0;
      cnt             <= '0;
      calibrated_o    <= 1'b0;
      overrun_o       <= 1'b0;
      bus.bit_valid_o <= 1'b0;
    end else begin
      case (state)
        SETTLE: if (take) cnt <= settle_done ? '0 : cnt + 9'd1;
        ACCUM: if (take) begin
          acc <= sum;
          cnt <= accum_done ? '0 : cnt + 9'd1;
          if (accum_done) begin
            compare_point_o <= 16'(sum >> LOG2_AVG);
            calibrated_o    <= 1'b1;
          end
        end
        default: ;
      endcase

      // Load when empty or draining this cycle; otherwise drop and flag overrun.
      if (new_bit) begin
        if (!bus.bit_valid_o || bus.bit_ready_i) begin
          bus.bit_o       <= (bus.sample_i < compare_point_o);
          bus.bit_valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (bus.bit_valid_o && bus.bit_ready_i) begin
        bus.bit_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frequency_counter_calibrator.sv
// Directed bench: calibration sequences, a slicing/backpressure vector table, restart and async reset.
module tb_frequency_counter_calibrator;
  logic        clk_200M = 1'b0;
  logic        reset_n_200M = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] compare_point_o;
  logic        calibrated_o, busy_o, overrun_o;
  int          checks = 0;
  int          errors = 0;

  frequency_counter_calibrator_if bus ();

  frequency_counter_calibrator #(.SETTLE_SAMPLES(4), .LOG2_AVG(6)) dut (
    .clk_200M        (clk_200M),
    .reset_n_200M    (reset_n_200M),
    .start_i         (start_i),
    .bus             (bus),
    .compare_point_o (compare_point_o),
    .calibrated_o    (calibrated_o),
    .busy_o          (busy_o),
    .overrun_o       (overrun_o)
  );

  always #5 clk_200M = ~clk_200M;

  typedef struct {
    logic        valid;
    logic [15:0] sample;
    logic        ready;
    logic        exp_bv;
    logic        exp_bit;
    logic        exp_ovr;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample outputs 1 time unit after the edge.
  task automatic cyc(input logic st, input logic v, input logic [15:0] s, input logic rdy);
    start_i            = st;
    bus.sample_valid_i = v;
    bus.sample_i       = s;
    bus.bit_ready_i    = rdy;
    @(posedge clk_200M);
    #1;
    start_i            = 1'b0;
    bus.sample_valid_i = 1'b0;
  endtask

  function automatic logic [15:0] acc_sample(input int mode, input int i);
    case (mode)
      1:       return (i % 2 == 0) ? 16'd198 : 16'd202;
      2:       return (i == 63) ? 16'd163 : 16'd100;
      3:       return 16'hFFFF;
      default: return 16'd200;
    endcase
  endfunction

  // start, 4 settle samples of 500, 64 accumulation samples; mode 1 inserts idle gaps.
  task automatic calibrate(input int mode, input logic [15:0] exp_cp);
    logic [15:0] old_cp;
    int          busy_bad;
    old_cp   = compare_point_o;
    busy_bad = 0;
    cyc(1'b1, 1'b0, 16'd0, 1'b1);
    chk("start_busy", busy_o, 1'b1);
    chk("start_cal_clear", calibrated_o, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 16'd500, 1'b1);
      if (busy_o !== 1'b1 || calibrated_o !== 1'b0) busy_bad++;
    end
    for (int i = 0; i < 64; i++) begin
      if (mode == 1 && i % 5 == 0) cyc(1'b0, 1'b0, 16'd0, 1'b1);
      cyc(1'b0, 1'b1, acc_sample(mode, i), 1'b1);
      if (i < 63 && (busy_o !== 1'b1 || calibrated_o !== 1'b0 || compare_point_o !== old_cp))
        busy_bad++;
    end
    chk("calib_busy_window", busy_bad, 0);
    chk("calib_cp", compare_point_o, exp_cp);
    chk("calib_cal", calibrated_o, 1'b1);
    chk("calib_busy_fall", busy_o, 1'b0);
    chk("calib_no_bit", bus.bit_valid_o, 1'b0);
  endtask

  initial begin
    int bad;
    bus.sample_i       = '0;
    bus.sample_valid_i = 1'b0;
    bus.bit_ready_i    = 1'b1;

    vecs[0]  = '{1'b1, 16'd199, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 16'd200, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 16'd201, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 16'd0,   1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 16'd150, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 16'd250, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 16'd0,   1'b0, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 16'd0,   1'b1, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 16'd100, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 16'd300, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 16'd0,   1'b1, 1'b0, 1'b0, 1'b1};

    // Reset values, then samples with no start_i must stay ignored.
    repeat (3) @(posedge clk_200M);
    #1;
    chk("rst_cp", compare_point_o, 16'd0);
    chk("rst_flags", {calibrated_o, busy_o, overrun_o, bus.bit_valid_o, bus.bit_o}, 5'b0);
    reset_n_200M = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, 16'(123 * i), 1'b0);
      if (bus.bit_valid_o !== 1'b0 || busy_o !== 1'b0 || calibrated_o !== 1'b0 ||
          compare_point_o !== 16'd0 || overrun_o !== 1'b0) bad++;
    end
    chk("idle_ignores_samples", bad, 0);

    calibrate(1, 16'd200);
    calibrate(2, 16'd100);
    calibrate(3, 16'hFFFF);
    calibrate(0, 16'd200);

    for (int i = 0; i < 11; i++) begin
      cyc(1'b0, vecs[i].valid, vecs[i].sample, vecs[i].ready);
      chk($sformatf("vec%0d_valid", i), bus.bit_valid_o, vecs[i].exp_bv);
      chk($sformatf("vec%0d_bit", i), bus.bit_o, vecs[i].exp_bit);
      chk($sformatf("vec%0d_overrun", i), overrun_o, vecs[i].exp_ovr);
    end
    chk("run_cal_held", calibrated_o, 1'b1);

    // Restart mid-accumulation, then a start coincident with a sample.
    cyc(1'b1, 1'b0, 16'd0, 1'b1);
    chk("restart_clears", {calibrated_o, overrun_o, bus.bit_valid_o, busy_o}, 4'b0001);
    chk("restart_cp_kept", compare_point_o, 16'd200);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 16'd500, 1'b1);
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, 16'd999, 1'b1);
    cyc(1'b1, 1'b1, 16'd7777, 1'b1);
    chk("restart2_busy", busy_o, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 16'd500, 1'b1);
    for (int i = 0; i < 63; i++) cyc(1'b0, 1'b1, 16'd40, 1'b1);
    chk("restart_cp_before_done", compare_point_o, 16'd200);
    chk("restart_not_cal", calibrated_o, 1'b0);
    cyc(1'b0, 1'b1, 16'd40, 1'b1);
    chk("restart_cp_new", compare_point_o, 16'd40);
    chk("restart_cal", calibrated_o, 1'b1);

    // Asynchronous reset in the middle of accumulation.
    cyc(1'b1, 1'b0, 16'd0, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 16'd900, 1'b1);
    #2;
    reset_n_200M = 1'b0;
    #1;
    chk("async_rst_cp", compare_point_o, 16'd0);
    chk("async_rst_flags", {calibrated_o, busy_o, overrun_o, bus.bit_valid_o}, 4'b0);
    @(posedge clk_200M);
    #1;
    reset_n_200M = 1'b1;
    cyc(1'b0, 1'b1, 16'd5, 1'b1);
    chk("post_rst_idle", {busy_o, bus.bit_valid_o}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frequency_counter_calibrator.md
# frequency_counter_calibrator

Calibrates and sequences the FM receive frequency counter in the 200 MHz domain. On request it discards settling samples, then averages the period-count samples to find the carrier's centre count and holds it as the decision threshold. After calibration it slices each new sample into a demodulated bit and delivers the bits downstream over a valid/ready handshake. It sits between the frequency counter's sample output and the bit-level deframer.

## Interface
Parameters:
- SETTLE_SAMPLES, 4: number of valid samples discarded after start before accumulation; range 0..255.
- LOG2_AVG, 6: log2 of the number of samples averaged (64 by default); range 0..8.

Ports:
- clk_200M  in  1  reference clock; all logic on its rising edge.
- reset_n_200M  in  1  asynchronous, active-low reset.
- start_i  in  1  single-cycle pulse that starts or restarts calibration; accepted in any state.
- sample_i  in  16  period count of the latest frequency counter sample.
- sample_valid_i  in  1  single-cycle pulse; sample_i is valid in this cycle.
- bit_ready_i  in  1  downstream can accept a bit.
- compare_point_o  out  16  current decision threshold.
- calibrated_o  out  1  high once a threshold has been computed since the last start_i.
- busy_o  out  1  high in SETTLE or ACCUM.
- bit_o  out  1  demodulated bit; 1 means the input frequency is above the centre frequency.
- bit_valid_o  out  1  bit_o holds an unconsumed bit.
- overrun_o  out  1  sticky flag: a bit was dropped because of backpressure.

## Operation
- States: IDLE, SETTLE, ACCUM, RUN. Reset enters IDLE.
- Reset values:
  - compare_point_o = 0.
  - calibrated_o, busy_o, bit_o, bit_valid_o and overrun_o = 0.
  - Accumulator and sample counter = 0.
- start_i in any state:
  - Clears the accumulator and the sample counter.
  - Clears calibrated_o, bit_valid_o and overrun_o.
  - Moves to SETTLE, or directly to ACCUM if SETTLE_SAMPLES = 0.
  - compare_point_o keeps its previous value.
  - start_i takes priority over a coincident sample_valid_i; that sample is ignored.
- IDLE: samples are ignored.
- SETTLE: counts valid samples. On the SETTLE_SAMPLES-th sample, the counter clears and the state moves to ACCUM. Settling samples are not accumulated.
- ACCUM:
  - Accumulator is 16+LOG2_AVG bits wide and cannot overflow.
  - Each valid sample adds sample_i to the accumulator.
  - On the 2^LOG2_AVG-th sample: compare_point_o <= (acc + sample_i) >> LOG2_AVG (truncated, no rounding), calibrated_o <= 1, state moves to RUN.
- RUN: each valid sample computes bit = (sample_i < compare_point_o). A sample equal to the threshold gives 0.
- Output handshake:
  - A bit transfers in any cycle where bit_valid_o and bit_ready_i are both high.
  - New bit with the register empty, or being consumed in the same cycle: load bit_o and set bit_valid_o.
  - New bit while bit_valid_o is high and bit_ready_i is low: the new bit is dropped, the old bit is held, and overrun_o is set.
  - overrun_o clears only on start_i or reset.
  - Transfer with no new bit: bit_valid_o clears.
- The accumulator is not updated in RUN.

## Timing
- All outputs are registered.
- SETTLE -> ACCUM, ACCUM -> RUN and the compare_point_o update happen on the edge that consumes the qualifying sample.
- Bit latency: bit_valid_o and bit_o appear 1 cycle after sample_valid_i.
- calibrated_o rises on the same edge that compare_point_o updates.
- busy_o falls on that same edge.
- Total calibration takes SETTLE_SAMPLES + 2^LOG2_AVG valid samples after start_i.
- The block does not assume a fixed spacing between sample_valid_i pulses. Pulses on back-to-back cycles must be handled.
- Asynchronous reset mid-calibration immediately restores every reset value, including compare_point_o = 0.

## Test plan
- Reset values:
  - Stimulus: assert reset; after release, drive samples with no start_i.
  - Required: compare_point_o = 0, all flags 0, state stays IDLE, and no bit_valid_o ever rises.
- Basic calibration:
  - Stimulus: start_i, then 4 samples of 500 followed by 64 samples of 200 (defaults).
  - Required: settling samples are excluded; compare_point_o = 200 and calibrated_o = 1 on the 68th sample's edge; busy_o is high between start_i and that edge.
- Averaging arithmetic:
  - Stimulus: 64 samples alternating 198/202 → required compare_point_o = 200.
  - Stimulus: 63 samples of 100 plus one of 163 → required compare_point_o = 100 (truncation of 6463/64).
  - Stimulus: 64 samples of 65535 → required compare_point_o = 65535 (no overflow).
- Slicing:
  - Stimulus: in RUN with compare_point_o = 200 and bit_ready_i = 1, samples 199, 200, 201.
  - Required: bits 1, 0, 0, each appearing one cycle after its sample.
- Backpressure:
  - Stimulus: bit_ready_i = 0; samples 150 then 250.
  - Required: bit_o stays 1, overrun_o = 1, and the bit is consumed when bit_ready_i rises.
  - Stimulus: a sample coincident with a transfer.
  - Required: bit_valid_o stays high with the new bit and no overrun.
- Restart:
  - Stimulus: start_i after the 30th ACCUM sample, and start_i coincident with a sample_valid_i.
  - Required: the accumulation restarts from zero, the coincident sample is ignored, and the old compare_point_o is retained until the new result.
